// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared router types and helpers. It provides the port identifiers, the flit
// layout, the input-unit state encoding, the XY routing function and the
// port-to-one-hot decoder.
// No ports (package).
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int NUM_OF_PORTS = 5;
    localparam int COORD_W      = 4;
    localparam int PAYLOAD_W    = 16;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        EAST  = 3'd2,
        SOUTH = 3'd3,
        WEST  = 3'd4
    } PORT_ID_t;

    typedef enum logic [1:0] {
        HEAD_FLIT = 2'd0,
        BODY_FLIT = 2'd1,
        TAIL_FLIT = 2'd2
    } FLIT_TYPE_t;

    typedef struct packed {
        logic                 valid;
        FLIT_TYPE_t           flit_type;
        logic [COORD_W-1:0]   dest_x;
        logic [COORD_W-1:0]   dest_y;
        logic [PAYLOAD_W-1:0] payload;
    } FLIT_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROUTING = 2'd1,
        WAITING = 2'd2,
        ACTIVE  = 2'd3
    } GLOBAL_STATE_t;

    // Dimension-ordered routing: resolve X first, then Y.
    function automatic PORT_ID_t xy_route(
        input logic [COORD_W-1:0] dest_x,
        input logic [COORD_W-1:0] dest_y,
        input logic [COORD_W-1:0] cur_x,
        input logic [COORD_W-1:0] cur_y
    );
        PORT_ID_t port;
        if (dest_x > cur_x) begin
            port = EAST;
        end else if (dest_x < cur_x) begin
            port = WEST;
        end else if (dest_y > cur_y) begin
            port = NORTH;
        end else if (dest_y < cur_y) begin
            port = SOUTH;
        end else begin
            port = LOCAL;
        end
        return port;
    endfunction

    function automatic logic [NUM_OF_PORTS-1:0] port_onehot(input PORT_ID_t port);
        return {{(NUM_OF_PORTS-1){1'b0}}, 1'b1} << port;
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// -----------------------------------------------------------------------------
// flit_fifo
// Circular flit buffer. The depth must be a power of two, so the pointers wrap
// naturally. The occupancy counter distinguishes full from empty.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   push_i       - write wdata_i (ignored when full)
//   wdata_i      - flit to store
//   pop_i        - discard the head entry (ignored when empty)
//   rdata_o      - current head entry (combinational read)
//   full_o       - no free entries
//   empty_o      - no stored entries
//   count_o      - number of stored entries
// -----------------------------------------------------------------------------
module flit_fifo
    import router_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter type flit_t = FLIT_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  flit_t                      wdata_i,
    input  logic                       pop_i,
    output flit_t                      rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    flit_t              mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               do_push_s;
    logic               do_pop_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;

    // Occupancy next state: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/input_unit.sv
// -----------------------------------------------------------------------------
// input_unit
// Router input stage. It buffers upstream flits and XY-routes each packet from
// its head flit. It then holds a one-hot request until that output port
// acknowledges, and streams the packet to the switch until the tail is popped.
// Ports:
//   clk, reset     - clock and synchronous active-high reset
//   i_flit         - upstream flit, qualified by its valid field
//   o_ready        - buffer has room this cycle
//   i_outport_ack  - one-hot grant from the output units
//   o_switch_req   - one-hot request for the latched output port
//   o_flit         - flit to the switch, all-zero when none is sent
//   o_route        - latched output port of the current packet
//   o_gstate       - FSM state
//   o_proto_err    - one-cycle pulse when a stray non-head flit is dropped
// -----------------------------------------------------------------------------
module input_unit
    import router_pkg::*;
#(
    parameter int BUF_DEPTH = 4,
    parameter int CUR_X     = 0,
    parameter int CUR_Y     = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  FLIT_t                   i_flit,
    output logic                    o_ready,
    input  logic [NUM_OF_PORTS-1:0] i_outport_ack,
    output logic [NUM_OF_PORTS-1:0] o_switch_req,
    output FLIT_t                   o_flit,
    output PORT_ID_t                o_route,
    output GLOBAL_STATE_t           o_gstate,
    output logic                    o_proto_err
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [COORD_W-1:0] CUR_X_C = COORD_W'(CUR_X);
    localparam logic [COORD_W-1:0] CUR_Y_C = COORD_W'(CUR_Y);

    GLOBAL_STATE_t            state_q;
    PORT_ID_t                 route_q;
    logic [NUM_OF_PORTS-1:0]  req_q;
    logic                     perr_q;

    FLIT_t                    head_s;
    logic                     full_s;
    logic                     empty_s;
    logic [CNT_W-1:0]         count_s;
    logic                     push_s;
    logic                     pop_s;
    logic                     stray_s;
    PORT_ID_t                 route_s;

    // When full, an offered flit is the upstream's violation and is dropped.
    assign push_s  = i_flit.valid && !full_s;
    assign o_ready = (count_s < CNT_W'(BUF_DEPTH)) && !reset;
    assign stray_s = !empty_s && (head_s.flit_type != HEAD_FLIT);
    assign route_s = xy_route(head_s.dest_x, head_s.dest_y, CUR_X_C, CUR_Y_C);

    flit_fifo #(
        .DEPTH  (BUF_DEPTH),
        .flit_t (FLIT_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_s),
        .wdata_i (i_flit),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count_s)
    );

    // Pop on every streamed flit in ACTIVE and on stray non-head flits in IDLE.
    always_comb begin
        pop_s  = 1'b0;
        o_flit = '0;
        if (state_q == ACTIVE && !empty_s) begin
            pop_s  = 1'b1;
            o_flit = head_s;
        end else if (state_q == IDLE && stray_s) begin
            pop_s  = 1'b1;
            o_flit = '0;
        end else begin
            pop_s  = 1'b0;
            o_flit = '0;
        end
    end

    // Packet FSM with its registered outputs: route, request and error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            route_q <= LOCAL;
            req_q   <= {NUM_OF_PORTS{1'b0}};
            perr_q  <= 1'b0;
        end else begin
            perr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!empty_s) begin
                        if (head_s.flit_type == HEAD_FLIT) begin
                            state_q <= ROUTING;
                        end else begin
                            perr_q <= 1'b1;
                        end
                    end
                end
                ROUTING: begin
                    route_q <= route_s;
                    req_q   <= port_onehot(route_s);
                    state_q <= WAITING;
                end
                WAITING: begin
                    // req_q is one-hot on route_q, so only the requested ack bit counts.
                    if ((i_outport_ack & req_q) != {NUM_OF_PORTS{1'b0}}) begin
                        req_q   <= {NUM_OF_PORTS{1'b0}};
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (!empty_s && head_s.flit_type == TAIL_FLIT) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_switch_req = req_q;
    assign o_route      = route_q;
    assign o_gstate     = state_q;
    assign o_proto_err  = perr_q;

endmodule

// File: tb/tb_input_unit.sv
// -----------------------------------------------------------------------------
// tb_input_unit
// Self-checking bench for input_unit at router position (1,1), buffer depth 4.
// The reference model computes the expected XY port from destination
// arithmetic. It keeps each packet's flits in a queue to predict the order and
// content of the streamed output.
// -----------------------------------------------------------------------------
module tb_input_unit;
    import router_pkg::*;

    localparam int CX = 1;
    localparam int CY = 1;

    logic                    clk = 1'b0;
    logic                    reset;
    FLIT_t                   in_flit;
    logic                    ready;
    logic [NUM_OF_PORTS-1:0] ack;
    logic [NUM_OF_PORTS-1:0] req;
    FLIT_t                   out_flit;
    PORT_ID_t                route;
    GLOBAL_STATE_t           gstate;
    logic                    perr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    input_unit #(
        .BUF_DEPTH (4),
        .CUR_X     (CX),
        .CUR_Y     (CY)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_flit        (in_flit),
        .o_ready       (ready),
        .i_outport_ack (ack),
        .o_switch_req  (req),
        .o_flit        (out_flit),
        .o_route       (route),
        .o_gstate      (gstate),
        .o_proto_err   (perr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected port index from plain coordinate comparison.
    function automatic int ref_port(input int dx, input int dy);
        if (dx > CX)      return 2;
        else if (dx < CX) return 4;
        else if (dy > CY) return 1;
        else if (dy < CY) return 3;
        else              return 0;
    endfunction

    function automatic FLIT_t mk(input FLIT_TYPE_t t, input int dx, input int dy);
        FLIT_t f;
        f.valid     = 1'b1;
        f.flit_type = t;
        f.dest_x    = COORD_W'(dx);
        f.dest_y    = COORD_W'(dy);
        f.payload   = PAYLOAD_W'($urandom);
        return f;
    endfunction

    // One packet: push, check request timing, optionally distract with wrong
    // acks and a flit offered while full, then grant and check the stream.
    task automatic run_packet(input int len, input int dx, input int dy, input bit wrong_ack);
        FLIT_t pkt[$];
        FLIT_t junk;
        int    p;
        int    w;
        logic [NUM_OF_PORTS-1:0] exp_req;
        p       = ref_port(dx, dy);
        exp_req = NUM_OF_PORTS'(1 << p);
        for (int i = 0; i < len; i++) begin
            pkt.push_back(mk(i == 0 ? HEAD_FLIT : (i == len - 1 ? TAIL_FLIT : BODY_FLIT), dx, dy));
        end
        junk = mk(HEAD_FLIT, dx, dy);
        @(negedge clk);
        in_flit = pkt[0];
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 2) check("req_early", 32'(req), 32'(0));
            if (k == 3) begin
                check("req_t3", 32'(req), 32'(exp_req));
                check("route", 32'(route), 32'(p));
                check("state_wait", 32'(gstate), 32'(WAITING));
            end
            in_flit = (k < len) ? pkt[k] : FLIT_t'(0);
        end
        w = $urandom_range(1, 3);
        for (int j = 0; j < w; j++) begin
            @(negedge clk);
            check("hold_state", 32'(gstate), 32'(WAITING));
            check("hold_req", 32'(req), 32'(exp_req));
            check("ready_fill", 32'(ready), 32'(len < 4));
            in_flit = (len == 4) ? junk : FLIT_t'(0);
            ack = wrong_ack ? NUM_OF_PORTS'(1 << ((p + 1 + $urandom_range(0, 3)) % 5)) : '0;
        end
        @(negedge clk);
        check("still_wait", 32'(gstate), 32'(WAITING));
        in_flit = '0;
        ack     = exp_req;
        @(negedge clk);
        ack = '0;
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            check("stream_state", 32'(gstate), 32'(ACTIVE));
            check("stream_flit", 32'(out_flit), 32'(pkt[i]));
            check("stream_req", 32'(req), 32'(0));
        end
        @(negedge clk);
        check("end_idle", 32'(gstate), 32'(IDLE));
        check("end_bubble", 32'(out_flit), 32'(0));
        @(negedge clk);
        check("no_ghost", 32'(gstate), 32'(IDLE));
    endtask

    task automatic run_stray(input FLIT_TYPE_t t);
        int pulses = 0;
        int reqs   = 0;
        @(negedge clk);
        in_flit = mk(t, 3, 3);
        @(negedge clk);
        in_flit = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (perr) pulses++;
            if (req != '0) reqs++;
        end
        check("perr_pulses", 32'(pulses), 32'(1));
        check("perr_noreq", 32'(reqs), 32'(0));
        check("perr_idle", 32'(gstate), 32'(IDLE));
        check("perr_ready", 32'(ready), 32'(1));
    endtask

    task automatic run_reset_mid();
        FLIT_t pkt[4];
        bit    seen = 1'b0;
        for (int i = 0; i < 4; i++) pkt[i] = mk(i == 0 ? HEAD_FLIT : (i == 3 ? TAIL_FLIT : BODY_FLIT), 2, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_flit = pkt[i];
        end
        @(negedge clk);
        in_flit = '0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (req != '0) seen = 1'b1;
            else @(negedge clk);
        end
        check("rst_req_seen", 32'(seen), 32'(1));
        ack = 5'b00100;
        @(negedge clk);
        ack = '0;
        check("rst_first_flit", 32'(out_flit), 32'(pkt[0]));
        reset = 1'b1;
        @(negedge clk);
        check("rst_state", 32'(gstate), 32'(IDLE));
        check("rst_flit", 32'(out_flit), 32'(0));
        check("rst_ready_low", 32'(ready), 32'(0));
        check("rst_req", 32'(req), 32'(0));
        check("rst_route", 32'(route), 32'(LOCAL));
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_ready", 32'(ready), 32'(1));
            check("rst_empty_idle", 32'(gstate), 32'(IDLE));
        end
    endtask

    initial begin
        reset   = 1'b1;
        in_flit = '0;
        ack     = '0;
        @(negedge clk);
        check("reset_ready", 32'(ready), 32'(0));
        check("reset_state", 32'(gstate), 32'(IDLE));
        check("reset_req", 32'(req), 32'(0));
        check("reset_flit", 32'(out_flit), 32'(0));
        check("reset_perr", 32'(perr), 32'(0));
        check("reset_route", 32'(route), 32'(LOCAL));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(ready), 32'(1));

        run_packet(3, 2, 0, 1'b0);   // east
        run_packet(2, 1, 1, 1'b0);   // local
        run_packet(3, 0, 0, 1'b1);   // west, with wrong acks
        run_packet(4, 1, 3, 1'b1);   // north, fills buffer
        run_packet(4, 1, 0, 1'b0);   // south, fills buffer
        run_stray(BODY_FLIT);
        run_stray(TAIL_FLIT);
        for (int n = 0; n < 20; n++) begin
            run_packet($urandom_range(2, 4), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        run_reset_mid();
        run_packet(3, 3, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
